// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core with a single shared instruction/data memory.
// Sequences FETCH/DECODE/EXECUTE/WRITEBACK and drives every datapath enable and mux select.
module multicycle_ctrl #(
    parameter int          MEM_TIMEOUT = 0,
    parameter int unsigned TO_W        = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       MEM_REQ,
    output logic       MEM_WRITE,
    output logic       ADR_SRC,
    output logic       IR_WRITE,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] RES_SRC,
    output logic [2:0] IMM_SRC,
    output logic [3:0] ALU_CONTROL,
    output logic       INSTR_DONE,
    output logic       TRAP
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_WB  = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam bit            TO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LIMIT = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : {TO_W{1'b0}};

    function automatic logic [3:0] alu_decode(input logic [2:0] fn3, input logic use_sub, input logic use_sra);
        case (fn3)
            3'b000:  alu_decode = use_sub ? 4'b0001 : 4'b0000;
            3'b001:  alu_decode = 4'b1110;
            3'b010:  alu_decode = 4'b1000;
            3'b011:  alu_decode = 4'b1001;
            3'b100:  alu_decode = 4'b0110;
            3'b101:  alu_decode = use_sra ? 4'b1111 : 4'b1101;
            3'b110:  alu_decode = 4'b0101;
            3'b111:  alu_decode = 4'b0100;
            default: alu_decode = 4'b0000;
        endcase
    endfunction

    // Compare ops: ZERO of a sub is equality, ZERO of slt/sltu means "not less than".
    function automatic logic branch_taken(input logic [2:0] fn3, input logic zero);
        case (fn3)
            3'b000:          branch_taken = zero;
            3'b001:          branch_taken = ~zero;
            3'b100, 3'b110:  branch_taken = ~zero;
            3'b101, 3'b111:  branch_taken = zero;
            default:         branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] branch_alu(input logic [2:0] fn3);
        case (fn3)
            3'b000, 3'b001:  branch_alu = 4'b0001;
            3'b100, 3'b101:  branch_alu = 4'b1000;
            3'b110, 3'b111:  branch_alu = 4'b1001;
            default:         branch_alu = 4'b0000;
        endcase
    endfunction

    state_t          state_q, state_d, nxt_s;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            req_state_s, mem_wait_s, timeout_s;
    logic            mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, done_s, trap_s;

    assign req_state_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign mem_wait_s  = req_state_s && !MEM_READY;
    assign timeout_s   = TO_EN && mem_wait_s && (to_cnt_q == TO_LIMIT);

    // State and timeout counter registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_FETCH;
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state and timeout counter logic
    always_comb begin
        nxt_s = state_q;
        case (state_q)
            S_FETCH:    nxt_s = MEM_READY ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt_s = S_MEMADR;
                    OP_R:              nxt_s = S_EXEC_R;
                    OP_I:              nxt_s = S_EXEC_I;
                    OP_BR:             nxt_s = S_BRANCH;
                    OP_JAL:            nxt_s = S_JAL;
                    OP_JALR:           nxt_s = S_JALR;
                    OP_LUI:            nxt_s = S_LUI;
                    OP_AUIPC:          nxt_s = S_AUIPC;
                    default:           nxt_s = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt_s = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_s = MEM_READY ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt_s = S_FETCH;
            S_MEMWRITE: nxt_s = MEM_READY ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   nxt_s = S_ALUWB;
            S_EXEC_I:   nxt_s = S_ALUWB;
            S_ALUWB:    nxt_s = S_FETCH;
            S_BRANCH:   nxt_s = (f3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            S_JAL:      nxt_s = S_ALUWB;
            S_JALR:     nxt_s = S_JALR_WB;
            S_JALR_WB:  nxt_s = S_FETCH;
            S_LUI:      nxt_s = S_FETCH;
            S_AUIPC:    nxt_s = S_FETCH;
            S_TRAP:     nxt_s = S_TRAP;
            default:    nxt_s = S_TRAP;
        endcase
        state_d  = timeout_s ? S_TRAP : nxt_s;
        to_cnt_d = (mem_wait_s && !timeout_s) ? (to_cnt_q + TO_W'(1)) : {TO_W{1'b0}};
    end

    // Moore output decode with the MEM_READY and branch-condition gated terms
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        done_s      = 1'b0;
        trap_s      = 1'b0;
        ADR_SRC     = 1'b0;
        ALU_SRC_A   = 2'b00;
        ALU_SRC_B   = 2'b00;
        RES_SRC     = 2'b00;
        IMM_SRC     = 3'b000;
        ALU_CONTROL = 4'b0000;
        case (state_q)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = MEM_READY;
                pc_write_s = MEM_READY;
                ALU_SRC_B  = 2'b10;
                RES_SRC    = 2'b10;
            end
            S_DECODE: begin
                ALU_SRC_A = 2'b01;
                ALU_SRC_B = 2'b01;
                case (op)
                    OP_BR:    IMM_SRC = 3'b010;
                    OP_JAL:   IMM_SRC = 3'b100;
                    OP_AUIPC: IMM_SRC = 3'b011;
                    default:  IMM_SRC = 3'b000;
                endcase
            end
            S_MEMADR: begin
                ALU_SRC_A = 2'b10;
                ALU_SRC_B = 2'b01;
                IMM_SRC   = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                ADR_SRC   = 1'b1;
            end
            S_MEMWB: begin
                RES_SRC     = 2'b01;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                ADR_SRC     = 1'b1;
                done_s      = MEM_READY;
            end
            S_EXEC_R: begin
                ALU_SRC_A   = 2'b10;
                ALU_CONTROL = alu_decode(f3, f7 == F7_ALT, f7 == F7_ALT);
            end
            S_EXEC_I: begin
                ALU_SRC_A   = 2'b10;
                ALU_SRC_B   = 2'b01;
                ALU_CONTROL = alu_decode(f3, 1'b0, f7 == F7_ALT);
            end
            S_ALUWB, S_AUIPC: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_BRANCH: begin
                ALU_SRC_A   = 2'b10;
                ALU_CONTROL = branch_alu(f3);
                pc_write_s  = branch_taken(f3, ZERO);
                done_s      = (f3[2:1] != 2'b01);
            end
            S_JAL: begin
                ALU_SRC_A  = 2'b01;
                ALU_SRC_B  = 2'b10;
                pc_write_s = 1'b1;
            end
            S_JALR: begin
                ALU_SRC_A  = 2'b10;
                ALU_SRC_B  = 2'b01;
                RES_SRC    = 2'b10;
                pc_write_s = 1'b1;
            end
            S_JALR_WB: begin
                ALU_SRC_A   = 2'b01;
                ALU_SRC_B   = 2'b10;
                RES_SRC     = 2'b10;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_LUI: begin
                ALU_SRC_A   = 2'b11;
                ALU_SRC_B   = 2'b01;
                IMM_SRC     = 3'b011;
                RES_SRC     = 2'b10;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_TRAP:  trap_s = 1'b1;
            default: trap_s = 1'b1;
        endcase
    end

    assign MEM_REQ    = mem_req_s   & ~RESET;
    assign MEM_WRITE  = mem_write_s & ~RESET;
    assign IR_WRITE   = ir_write_s  & ~RESET;
    assign PC_WRITE   = pc_write_s  & ~RESET;
    assign REG_WRITE  = reg_write_s & ~RESET;
    assign INSTR_DONE = done_s      & ~RESET;
    assign TRAP       = trap_s      & ~RESET;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table for instruction flows,
// plus hand-written sequences for reset, trap exit and memory timeout.
module tb_multicycle_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, rst_t, ZERO, MEM_READY, rdy_t;
    logic [6:0] op, f7;
    logic [2:0] f3;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, trap;
    logic [1:0] src_a, src_b, res_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctl;
    logic       mem_req_t, mem_write_t, adr_src_t, ir_write_t, pc_write_t, reg_write_t, instr_done_t, trap_t;
    logic [1:0] src_a_t, src_b_t, res_src_t;
    logic [2:0] imm_src_t;
    logic [3:0] alu_ctl_t;

    multicycle_ctrl dut (
        .CLK(CLK), .RESET(RESET), .op(op), .f3(f3), .f7(f7), .ZERO(ZERO), .MEM_READY(MEM_READY),
        .MEM_REQ(mem_req), .MEM_WRITE(mem_write), .ADR_SRC(adr_src), .IR_WRITE(ir_write),
        .PC_WRITE(pc_write), .REG_WRITE(reg_write), .ALU_SRC_A(src_a), .ALU_SRC_B(src_b),
        .RES_SRC(res_src), .IMM_SRC(imm_src), .ALU_CONTROL(alu_ctl), .INSTR_DONE(instr_done), .TRAP(trap)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .CLK(CLK), .RESET(rst_t), .op(op), .f3(f3), .f7(f7), .ZERO(ZERO), .MEM_READY(rdy_t),
        .MEM_REQ(mem_req_t), .MEM_WRITE(mem_write_t), .ADR_SRC(adr_src_t), .IR_WRITE(ir_write_t),
        .PC_WRITE(pc_write_t), .REG_WRITE(reg_write_t), .ALU_SRC_A(src_a_t), .ALU_SRC_B(src_b_t),
        .RES_SRC(res_src_t), .IMM_SRC(imm_src_t), .ALU_CONTROL(alu_ctl_t), .INSTR_DONE(instr_done_t), .TRAP(trap_t)
    );

    typedef struct packed {
        logic       mreq, mwr, adr, irw, pcw, rw;
        logic [1:0] a, b, res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       done, trap;
    } outs_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero, rdy;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011, OP_I = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] ALT = 7'b0100000, Z7 = 7'b0000000;

    vec_t  vecs[$];
    int    n_cmp = 0, n_bad = 0;
    outs_t F, FW, DI, DB, DJ, DU, WB, MR, MW, MWW, MA_L, MA_S, MWB, T, LUIo, JALo, JALRo, JWB;

    function automatic outs_t o(input logic mreq, mwr, adr, irw, pcw, rw, input logic [1:0] a, b, res,
                                input logic [2:0] imm, input logic [3:0] alu, input logic done, trp);
        o = {mreq, mwr, adr, irw, pcw, rw, a, b, res, imm, alu, done, trp};
    endfunction

    function automatic outs_t exr(input logic [3:0] alu);
        exr = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, alu, 1'b0, 1'b0);
    endfunction

    function automatic outs_t exi(input logic [3:0] alu);
        exi = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, alu, 1'b0, 1'b0);
    endfunction

    function automatic outs_t br(input logic taken, input logic [3:0] alu);
        br = o(1'b0, 1'b0, 1'b0, 1'b0, taken, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, alu, 1'b1, 1'b0);
    endfunction

    function automatic outs_t act_m();
        act_m = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, src_a, src_b, res_src,
                 imm_src, alu_ctl, instr_done, trap};
    endfunction

    function automatic outs_t act_t();
        act_t = {mem_req_t, mem_write_t, adr_src_t, ir_write_t, pc_write_t, reg_write_t, src_a_t, src_b_t,
                 res_src_t, imm_src_t, alu_ctl_t, instr_done_t, trap_t};
    endfunction

    function automatic logic [6:0] enables(input outs_t x);
        enables = {x.mreq, x.mwr, x.irw, x.pcw, x.rw, x.done, x.trap};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [6:0] op_i, input logic [2:0] f3_i, input logic [6:0] f7_i,
                       input logic z, input logic r, input outs_t e);
        vec_t v;
        v = {op_i, f3_i, f7_i, z, r, e};
        vecs.push_back(v);
    endtask

    // FETCH with MEM_READY=1, then the given DECODE/exec/(optional) writeback cycles
    task automatic seq(input logic [6:0] op_i, input logic [2:0] f3_i, input logic [6:0] f7_i, input logic z,
                       input outs_t d, input outs_t x, input outs_t w, input bit has_w);
        add(op_i, f3_i, f7_i, z, 1'b1, F);
        add(op_i, f3_i, f7_i, z, 1'b1, d);
        add(op_i, f3_i, f7_i, z, 1'b1, x);
        if (has_w) add(op_i, f3_i, f7_i, z, 1'b1, w);
    endtask

    // dut_to waiting in FETCH: four quiet cycles, then TRAP
    task automatic to_wait(input string name);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("%s_wait%0d", name, k), act_t(), FW);
            @(negedge CLK);
        end
        #1 chk($sformatf("%s_trap", name), act_t(), T);
    endtask

    initial begin
        RESET = 1'b1; rst_t = 1'b1; MEM_READY = 1'b1; rdy_t = 1'b1; ZERO = 1'b0;
        op = 7'b0; f3 = 3'b0; f7 = 7'b0;

        F    = o(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0, 1'b0);
        FW   = o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0, 1'b0);
        DI   = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
        DB   = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000, 1'b0, 1'b0);
        DJ   = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b100, 4'b0000, 1'b0, 1'b0);
        DU   = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b011, 4'b0000, 1'b0, 1'b0);
        WB   = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1, 1'b0);
        MA_L = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
        MA_S = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 1'b0, 1'b0);
        MR   = o(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
        MWB  = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 1'b1, 1'b0);
        MW   = o(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1, 1'b0);
        MWW  = o(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
        LUIo = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 2'b10, 3'b011, 4'b0000, 1'b1, 1'b0);
        JALo = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
        JALRo= o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0, 1'b0);
        JWB  = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b1, 1'b0);
        T    = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b1);

        seq(OP_I,  3'b000, Z7,  1'b0, DI, exi(4'b0000), WB, 1'b1);   // addi x5,x0,7
        seq(OP_R,  3'b000, Z7,  1'b0, DI, exr(4'b0000), WB, 1'b1);   // add x6,x5,x5
        seq(OP_R,  3'b000, ALT, 1'b0, DI, exr(4'b0001), WB, 1'b1);   // sub
        seq(OP_I,  3'b000, ALT, 1'b0, DI, exi(4'b0000), WB, 1'b1);   // addi with imm[10] set stays add
        seq(OP_R,  3'b101, ALT, 1'b0, DI, exr(4'b1111), WB, 1'b1);   // sra
        seq(OP_I,  3'b101, Z7,  1'b0, DI, exi(4'b1101), WB, 1'b1);   // srli
        seq(OP_R,  3'b011, Z7,  1'b0, DI, exr(4'b1001), WB, 1'b1);   // sltu
        seq(OP_I,  3'b111, Z7,  1'b0, DI, exi(4'b0100), WB, 1'b1);   // andi
        for (int k = 0; k < 3; k++) add(OP_LD, 3'b010, Z7, 1'b0, 1'b0, FW);   // lw, slow memory
        add(OP_LD, 3'b010, Z7, 1'b0, 1'b1, F);
        add(OP_LD, 3'b010, Z7, 1'b0, 1'b1, DI);
        add(OP_LD, 3'b010, Z7, 1'b0, 1'b1, MA_L);
        for (int k = 0; k < 3; k++) add(OP_LD, 3'b010, Z7, 1'b0, 1'b0, MR);
        add(OP_LD, 3'b010, Z7, 1'b0, 1'b1, MR);
        add(OP_LD, 3'b010, Z7, 1'b0, 1'b1, MWB);
        add(OP_ST, 3'b010, Z7, 1'b0, 1'b1, F);                                // sw
        add(OP_ST, 3'b010, Z7, 1'b0, 1'b1, DI);
        add(OP_ST, 3'b010, Z7, 1'b0, 1'b1, MA_S);
        add(OP_ST, 3'b010, Z7, 1'b0, 1'b1, MW);
        seq(OP_BR, 3'b000, Z7, 1'b1, DB, br(1'b1, 4'b0001), WB, 1'b0);   // beq, equal
        seq(OP_BR, 3'b001, Z7, 1'b1, DB, br(1'b0, 4'b0001), WB, 1'b0);   // bne, equal
        seq(OP_BR, 3'b100, Z7, 1'b0, DB, br(1'b1, 4'b1000), WB, 1'b0);   // blt, less
        seq(OP_BR, 3'b101, Z7, 1'b0, DB, br(1'b0, 4'b1000), WB, 1'b0);   // bge, less
        seq(OP_BR, 3'b111, Z7, 1'b1, DB, br(1'b1, 4'b1001), WB, 1'b0);   // bgeu, not less
        seq(OP_LUI,   3'b000, Z7, 1'b0, DI, LUIo,  WB,  1'b0);
        seq(OP_AUIPC, 3'b000, Z7, 1'b0, DU, WB,    WB,  1'b0);
        seq(OP_JAL,   3'b000, Z7, 1'b0, DJ, JALo,  WB,  1'b1);
        seq(OP_JALR,  3'b000, Z7, 1'b0, DI, JALRo, JWB, 1'b1);
        seq(7'b0000000, 3'b000, Z7, 1'b0, DI, T, T, 1'b1);               // illegal opcode

        @(negedge CLK);
        #1 chk("reset_enables", {25'd0, enables(act_m())}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; f3 = vecs[i].f3; f7 = vecs[i].f7;
            ZERO = vecs[i].zero; MEM_READY = vecs[i].rdy;
            #1 chk($sformatf("vec%0d_op%b_f3%b", i, vecs[i].op, vecs[i].f3), act_m(), vecs[i].exp);
            @(negedge CLK);
        end

        RESET = 1'b1;
        #1 chk("trap_reset_enables", {25'd0, enables(act_m())}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; MEM_READY = 1'b0;
        #1 chk("trap_exit_fetch", act_m(), FW);

        @(negedge CLK);
        rst_t = 1'b0; rdy_t = 1'b0;
        to_wait("timeout");

        @(negedge CLK) rst_t = 1'b1;
        @(negedge CLK);
        rst_t = 1'b0; rdy_t = 1'b1; op = OP_ST; f3 = 3'b010; f7 = Z7;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK) rdy_t = 1'b0;
        #1 chk("sw_memwrite_wait", act_t(), MWW);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK) rst_t = 1'b1;
        #1 chk("memwrite_reset_enables", {25'd0, enables(act_t())}, 32'd0);
        @(negedge CLK) rst_t = 1'b0;
        to_wait("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
